// File: rtl/memory_pkg.sv
// Shared types for the memory BIST: controller states, test phases and counter sizing.
package memory_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_CAP = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_W0 = 2'd0,
    PH_R0 = 2'd1,
    PH_W1 = 2'd2,
    PH_R1 = 2'd3
  } phase_t;

  // Two read phases of 2^A words each: up to 2^(A+1) errors, which needs A+2 bits.
  function automatic int err_w(input int addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/memory_bist_if.sv
// Test-control and memory-control signals of the BIST; the tri-state data bus stays a plain port.
interface memory_bist_if
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);

  logic                             start;
  logic [DATA_WIDTH-1:0]            pattern;
  logic                             busy;
  logic                             done;
  logic                             pass;
  logic [err_w(ADDR_WIDTH)-1:0]     err_count;
  logic [ADDR_WIDTH-1:0]            fail_addr;
  logic [DATA_WIDTH-1:0]            fail_data;
  logic                             fail_phase;
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic                             mem_wr;
  logic                             mem_rd;

  modport master (
    output start, pattern,
    input  busy, done, pass, err_count, fail_addr, fail_data, fail_phase,
    input  mem_addr, mem_wr, mem_rd
  );

  modport slave (
    input  start, pattern,
    output busy, done, pass, err_count, fail_addr, fail_data, fail_phase,
    output mem_addr, mem_wr, mem_rd
  );

endinterface

// File: rtl/bist_addr_gen.sv
// Up/down address counter; loads take priority over stepping and it never wraps on its own.
module bist_addr_gen #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_up,
  input  logic                  load_down,
  input  logic                  step,
  input  logic                  dir,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else if (load_up) begin
      addr <= '0;
    end else if (load_down) begin
      addr <= '1;
    end else if (step) begin
      addr <= dir ? addr + 1'b1 : addr - 1'b1;
    end
  end

  // dir=1 counts up, so the end of the sweep is the top address.
  assign last = dir ? (addr == '1) : (addr == '0);

endmodule

// File: rtl/memory_bist.sv
// March-style BIST master: W0 up, R0 up, W1(~pattern) down, R1 down, then reports pass/errors.
module memory_bist
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_bist_if.slave          ctl,
  inout  wire [DATA_WIDTH-1:0]  mem_data
);

  localparam int EW = err_w(ADDR_WIDTH);

  state_t                state;
  state_t                state_nxt;
  phase_t                phase;
  logic [DATA_WIDTH-1:0] pattern_q;
  logic [EW-1:0]         err_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_data_q;
  logic                  fail_phase_q;
  logic                  pass_q;

  logic                  busy_c;
  logic                  done_c;
  logic                  mem_wr_c;
  logic                  mem_rd_c;
  logic                  load_up;
  logic                  load_down;
  logic                  step;
  logic                  dir;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last;

  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  mismatch;
  logic                  accept;

  assign accept = (state == S_IDLE) && ctl.start;

  bist_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .load_up   (load_up),
    .load_down (load_down),
    .step      (step),
    .dir       (dir),
    .addr      (addr),
    .last      (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ctl.start) state_nxt = S_WR;
      S_WR:     if (last) state_nxt = S_RD_REQ;
      S_RD_REQ: state_nxt = S_RD_CAP;
      S_RD_CAP: begin
        if (!last) begin
          state_nxt = S_RD_REQ;
        end else if (phase == PH_R0) begin
          state_nxt = S_WR;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_c    = 1'b0;
    done_c    = 1'b0;
    mem_wr_c  = 1'b0;
    mem_rd_c  = 1'b0;
    load_up   = 1'b0;
    load_down = 1'b0;
    step      = 1'b0;
    dir       = (phase == PH_W0) || (phase == PH_R0);
    case (state)
      S_IDLE: begin
        load_up = ctl.start;
      end
      S_WR: begin
        busy_c    = 1'b1;
        mem_wr_c  = 1'b1;
        step      = !last;
        load_up   = last && (phase == PH_W0);
        load_down = last && (phase == PH_W1);
      end
      S_RD_REQ: begin
        busy_c   = 1'b1;
        mem_rd_c = 1'b1;
      end
      S_RD_CAP: begin
        busy_c    = 1'b1;
        mem_rd_c  = 1'b1;
        step      = !last;
        load_down = last && (phase == PH_R0);
      end
      S_DONE: begin
        done_c = 1'b1;
      end
      default: begin
        busy_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= PH_W0;
    end else if (accept) begin
      phase <= PH_W0;
    end else if ((state == S_WR) && last) begin
      phase <= (phase == PH_W0) ? PH_R0 : PH_R1;
    end else if ((state == S_RD_CAP) && last && (phase == PH_R0)) begin
      phase <= PH_W1;
    end
  end

  assign wr_word  = (phase == PH_W0) ? pattern_q : ~pattern_q;
  assign exp_word = (phase == PH_R0) ? pattern_q : ~pattern_q;
  assign mismatch = (state == S_RD_CAP) && (mem_data != exp_word);

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q    <= '0;
      err_q        <= '0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_phase_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      if (accept) begin
        pattern_q    <= ctl.pattern;
        err_q        <= '0;
        fail_addr_q  <= '0;
        fail_data_q  <= '0;
        fail_phase_q <= 1'b0;
        pass_q       <= 1'b0;
      end else if (mismatch) begin
        err_q <= err_q + 1'b1;
        // Only the first failure of a run is recorded.
        if (err_q == '0) begin
          fail_addr_q  <= addr;
          fail_data_q  <= mem_data;
          fail_phase_q <= (phase == PH_R1);
        end
      end
      if (state == S_DONE) begin
        pass_q <= (err_q == '0);
      end
    end
  end

  // The bus is only ever driven during write cycles; reads leave it to the memory.
  assign mem_data = mem_wr_c ? wr_word : {DATA_WIDTH{1'bz}};

  assign ctl.busy       = busy_c;
  assign ctl.done       = done_c;
  assign ctl.pass       = (state == S_DONE) ? (err_q == '0) : pass_q;
  assign ctl.err_count  = err_q;
  assign ctl.fail_addr  = fail_addr_q;
  assign ctl.fail_data  = fail_data_q;
  assign ctl.fail_phase = fail_phase_q;
  assign ctl.mem_addr   = addr;
  assign ctl.mem_wr     = mem_wr_c;
  assign ctl.mem_rd     = mem_rd_c;

endmodule

// File: tb/tb_memory_bist.sv
// Directed bench for memory_bist against a behavioural single-port memory with an optional stuck bit.
module tb_memory_bist;
  import memory_pkg::*;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int EW = err_w(AW);

  logic          clk = 1'b0;
  logic          rst;
  wire [DW-1:0]  mem_data;

  memory_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  memory_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctl      (bus),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read driven while mem_rd is held.
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_q;
  logic          fault_en;

  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= mem_data;
    if (bus.mem_rd) begin
      if (fault_en && bus.mem_addr == 5'd21) rd_q <= mem[bus.mem_addr] | 8'h01;
      else                                   rd_q <= mem[bus.mem_addr];
    end
  end

  assign mem_data = bus.mem_rd ? rd_q : {DW{1'bz}};

  function automatic bit floating(input logic [DW-1:0] v);
    if ($isunknown(v)) return v === {DW{1'bz}};
    return v == '0;
  endfunction

  int            n_wr;
  int            n_rd;
  int            n_bad;
  logic          mon_en;
  logic          mon_clr;
  logic [AW-1:0] wa [$];
  logic [DW-1:0] wd [$];

  always @(negedge clk) begin
    if (mon_clr) begin
      n_wr  <= 0;
      n_rd  <= 0;
      n_bad <= 0;
      wa.delete();
      wd.delete();
    end else if (mon_en) begin
      if (bus.mem_wr && bus.mem_rd) n_bad <= n_bad + 1;
      else if (!bus.mem_wr && !bus.mem_rd && !floating(mem_data)) n_bad <= n_bad + 1;
      if (bus.mem_wr) begin
        n_wr <= n_wr + 1;
        wa.push_back(bus.mem_addr);
        wd.push_back(mem_data);
      end
      if (bus.mem_rd) n_rd <= n_rd + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Starts a run in the first IDLE cycle and returns edges from the start edge to done.
  task automatic run_bist(input logic [DW-1:0] pat, input int mid_at, output int cyc);
    @(negedge clk);
    if (bus.done) @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = pat;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.pattern = ~pat;
    check("start_busy", 32'(bus.busy), 1);
    check("start_err_clear", 32'(bus.err_count), 0);
    check("start_pass_clear", 32'(bus.pass), 0);
    check("start_first_write", 32'({bus.mem_wr, bus.mem_addr}), 32'h20);
    cyc = 0;
    while (!bus.done && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.start) bus.start = 1'b0;
      if (cyc == mid_at) begin
        bus.start   = 1'b1;
        bus.pattern = 8'h00;
      end
    end
    check("done_seen", 32'(bus.done), 1);
    check("done_busy_low", 32'(bus.busy), 0);
  endtask

  int cyc;
  int order_err;

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pattern = '0;
    fault_en    = 1'b0;
    mon_en      = 1'b0;
    mon_clr     = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_pass", 32'(bus.pass), 0);
    check("rst_err", 32'(bus.err_count), 0);
    check("rst_fail", 32'({bus.fail_phase, bus.fail_addr, bus.fail_data}), 0);
    check("rst_mem_ctl", 32'({bus.mem_addr, bus.mem_wr, bus.mem_rd}), 0);
    check("rst_bus_z", 32'(floating(mem_data)), 1);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_hold", 32'({bus.busy, bus.mem_wr, bus.mem_rd}), 0);

    // Good memory, F0, with the bus monitor over the whole run
    mon_clr = 1'b0;
    mon_en  = 1'b1;
    run_bist(8'hF0, 0, cyc);
    check("good_cycles", 32'(cyc), 192);
    check("good_pass", 32'(bus.pass), 1);
    check("good_err", 32'(bus.err_count), 0);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    check("done_pulse", 32'(bus.done), 0);
    check("pass_hold", 32'(bus.pass), 1);
    check("mon_bus_rules", 32'(n_bad), 0);
    check("mon_writes", 32'(n_wr), 64);
    check("mon_captures", 32'(n_rd / 2), 64);
    order_err = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] != ((i < 32) ? 5'(i) : 5'(63 - i))) order_err++;
      if (wd[i] != ((i < 32) ? 8'hF0 : 8'h0F)) order_err++;
    end
    check("write_sequence", 32'(order_err), 0);

    // Stuck-at-1 on bit0 of address 21
    fault_en = 1'b1;
    run_bist(8'hAA, 0, cyc);
    check("fault_cycles", 32'(cyc), 192);
    check("fault_err", 32'(bus.err_count), 1);
    check("fault_addr", 32'(bus.fail_addr), 21);
    check("fault_data", 32'(bus.fail_data), 32'hAB);
    check("fault_phase", 32'(bus.fail_phase), 0);
    check("fault_pass", 32'(bus.pass), 0);

    // Back-to-back run with a start pulse in the middle of R0
    fault_en = 1'b0;
    run_bist(8'h3C, 50, cyc);
    check("mid_start_cycles", 32'(cyc), 192);
    check("mid_start_pass", 32'(bus.pass), 1);
    check("mid_start_err", 32'(bus.err_count), 0);

    // Reset during R1, then a clean run
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.pattern = 8'h3C;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (140) @(posedge clk);
    #1;
    check("r1_reading", 32'(bus.mem_rd), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ctl", 32'({bus.busy, bus.mem_rd, bus.mem_wr, bus.done}), 0);
    check("mid_rst_addr", 32'(bus.mem_addr), 0);
    check("mid_rst_bus_z", 32'(floating(mem_data)), 1);
    rst = 1'b0;
    run_bist(8'h55, 0, cyc);
    check("post_rst_cycles", 32'(cyc), 192);
    check("post_rst_pass", 32'(bus.pass), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
